ienc_loader: RTL and testbench

IENC_LOADER -- requirements
Module: ienc_loader

---
 rtl/ienc_loader.sv | 136 +++++++++++++
 tb/tb_ienc_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ienc_loader.sv
// Instruction encoder/loader: packs decoded instruction fields into 16-bit words and writes them
// sequentially into instruction memory. Optional immediate range checking via IENC_IMM_CHECK_EN.
module ienc_loader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  mnem,
  input  logic [2:0]  rn,
  input  logic [2:0]  rd,
  input  logic [2:0]  rm,
  input  logic [1:0]  sh,
  input  logic [15:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_addr,
  output logic [15:0] out_wdata,
  output logic [8:0]  count,
  output logic        done,
  output logic        full,
  output logic        err_illegal,
  output logic        err_imm
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] OP_MOV_IMM = 4'd0;
  localparam logic [3:0] OP_MOV     = 4'd1;
  localparam logic [3:0] OP_ADD     = 4'd2;
  localparam logic [3:0] OP_CMP     = 4'd3;
  localparam logic [3:0] OP_AND     = 4'd4;
  localparam logic [3:0] OP_MVN     = 4'd5;
  localparam logic [3:0] OP_LDR     = 4'd6;
  localparam logic [3:0] OP_STR     = 4'd7;
  localparam logic [3:0] OP_HALT    = 4'd8;

  logic [1:0]  state;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic        is_halt;
  logic [15:0] enc;
  logic        illegal;
  logic        imm_bad;

  assign illegal   = (mnem > OP_HALT);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == WRITE);
  assign done      = (state == DONE);
  assign out_addr  = addr;
  assign out_wdata = wdata;

  always_comb begin
    enc = 16'h0000;
    case (mnem)
      OP_MOV_IMM: enc = {3'b110, 2'b10, rn, imm[7:0]};
      OP_MOV:     enc = {3'b110, 2'b00, 3'b000, rd, sh, rm};
      OP_ADD:     enc = {3'b101, 2'b00, rn, rd, sh, rm};
      OP_CMP:     enc = {3'b101, 2'b01, rn, 3'b000, sh, rm};
      OP_AND:     enc = {3'b101, 2'b10, rn, rd, sh, rm};
      OP_MVN:     enc = {3'b101, 2'b11, 3'b000, rd, sh, rm};
      OP_LDR:     enc = {3'b011, 2'b00, rn, rd, imm[4:0]};
      OP_STR:     enc = {3'b100, 2'b00, rn, rd, imm[4:0]};
      OP_HALT:    enc = 16'hE000;
      default:    enc = 16'h0000;
    endcase
  end

`ifdef IENC_IMM_CHECK_EN
  // An immediate fits when every bit above the field's sign bit matches that sign bit.
  assign imm_bad = ((mnem == OP_MOV_IMM) && (imm[15:7] != {9{imm[7]}})) ||
                   (((mnem == OP_LDR) || (mnem == OP_STR)) && (imm[15:4] != {12{imm[4]}}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_imm <= 1'b0;
    else if (restart)
      err_imm <= 1'b0;
    else if ((state == IDLE) && in_valid && !illegal && imm_bad)
      err_imm <= 1'b1;
  end
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[15:8];
  assign imm_bad       = 1'b0;
  assign err_imm       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr        <= 8'h00;
      wdata       <= 16'h0000;
      is_halt     <= 1'b0;
      count       <= 9'd0;
      full        <= 1'b0;
      err_illegal <= 1'b0;
    end else if (restart) begin
      state       <= IDLE;
      addr        <= 8'h00;
      wdata       <= 16'h0000;
      is_halt     <= 1'b0;
      count       <= 9'd0;
      full        <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (illegal) begin
              err_illegal <= 1'b1;
            end else if (!imm_bad) begin
              wdata   <= enc;
              is_halt <= (mnem == OP_HALT);
              state   <= WRITE;
            end
          end
        end
        WRITE: begin
          if (out_ready) begin
            count <= count + 9'd1;
            addr  <= addr + 8'd1;
            if (addr == 8'hFF)
              full <= 1'b1;
            state <= (is_halt || (addr == 8'hFF)) ? DONE : IDLE;
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ienc_loader.sv
// Directed self-checking bench for ienc_loader; covers encodings, stalls, HALT/restart,
// illegal opcodes, memory-full, reset during a write and the IENC_IMM_CHECK_EN behaviour.
module tb_ienc_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  mnem = 4'd0;
  logic [2:0]  rn = 3'd0, rd = 3'd0, rm = 3'd0;
  logic [1:0]  sh = 2'd0;
  logic [15:0] imm = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_addr;
  logic [15:0] out_wdata;
  logic [8:0]  count;
  logic        done, full, err_illegal, err_imm;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_addr;

  ienc_loader dut (
    .clk(clk), .rst_n(rst_n), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready),
    .mnem(mnem), .rn(rn), .rd(rd), .rm(rm), .sh(sh), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_wdata(out_wdata),
    .count(count), .done(done), .full(full),
    .err_illegal(err_illegal), .err_imm(err_imm)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction for a single cycle; afterwards the bench sits 1 time unit past the accepting edge.
  task automatic send(input logic [3:0] m, input logic [2:0] n, input logic [2:0] d,
                      input logic [2:0] r, input logic [1:0] s, input logic [15:0] i);
    mnem = m; rn = n; rd = d; rm = r; sh = s; imm = i;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_addr !== 8'h00) begin n_err++; $display("[TB] FAIL reset_addr: got %h want 00", out_addr); end
    n_cmp++; if (out_wdata !== 16'h0000) begin n_err++; $display("[TB] FAIL reset_wdata: got %h want 0000", out_wdata); end
    n_cmp++; if (count !== 9'd0) begin n_err++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if ({done, full, err_illegal, err_imm} !== 4'b0000) begin n_err++; $display("[TB] FAIL reset_flags: got %b want 0000", {done, full, err_illegal, err_imm}); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_mov_imm();
    out_ready = 1'b1;
    send(4'd0, 3'd1, 3'd0, 3'd0, 2'd0, 16'd8);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL movimm_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_wdata !== 16'hD108) begin n_err++; $display("[TB] FAIL movimm_wdata: got %h want D108", out_wdata); end
    n_cmp++; if (out_addr !== 8'h00) begin n_err++; $display("[TB] FAIL movimm_addr: got %h want 00", out_addr); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL movimm_in_ready: got %b want 0", in_ready); end
    tick();
    n_cmp++; if (count !== 9'd1) begin n_err++; $display("[TB] FAIL movimm_count: got %0d want 1", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL movimm_valid_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    do_restart();
    out_ready = 1'b1;
    send(4'd2, 3'd4, 3'd5, 3'd7, 2'b01, 16'd0);
    n_cmp++; if (out_wdata !== 16'hA4AF || out_addr !== 8'h00) begin n_err++; $display("[TB] FAIL b2b_add: got %h@%h want A4AF@00", out_wdata, out_addr); end
    tick();
    send(4'd3, 3'd0, 3'd6, 3'd1, 2'b10, 16'd0);
    n_cmp++; if (out_wdata !== 16'hA811 || out_addr !== 8'h01) begin n_err++; $display("[TB] FAIL b2b_cmp: got %h@%h want A811@01", out_wdata, out_addr); end
    tick();
    n_cmp++; if (count !== 9'd2) begin n_err++; $display("[TB] FAIL b2b_count: got %0d want 2", count); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    send(4'd1, 3'd5, 3'd2, 3'd6, 2'b11, 16'hFFFF);
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_wdata !== 16'hC05E || out_addr !== 8'h02) begin n_err++; $display("[TB] FAIL stall_hold%0d: got v=%b %h@%h want v=1 C05E@02", k, out_valid, out_wdata, out_addr); end
      n_cmp++; if (in_ready !== 1'b0 || count !== 9'd2) begin n_err++; $display("[TB] FAIL stall_idle%0d: got rdy=%b cnt=%0d want rdy=0 cnt=2", k, in_ready, count); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (count !== 9'd3 || out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL stall_release: got cnt=%0d v=%b want cnt=3 v=0", count, out_valid); end
  endtask

  task automatic test_encodings();
    logic [3:0]  tm [4] = '{4'd4, 4'd5, 4'd6, 4'd7};
    logic [2:0]  tn [4] = '{3'd7, 3'd5, 3'd2, 3'd6};
    logic [2:0]  td [4] = '{3'd1, 3'd3, 3'd3, 3'd7};
    logic [2:0]  tr [4] = '{3'd2, 3'd4, 3'd0, 3'd0};
    logic [1:0]  ts [4] = '{2'd0, 2'd2, 2'd0, 2'd0};
    logic [15:0] ti [4] = '{16'd0, 16'd0, 16'hFFFD, 16'd5};
    logic [15:0] te [4] = '{16'hB722, 16'hB874, 16'h627D, 16'h86E5};
    exp_addr = 8'h03;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(tm[k], tn[k], td[k], tr[k], ts[k], ti[k]);
      n_cmp++; if (out_valid !== 1'b1 || out_wdata !== te[k] || out_addr !== exp_addr) begin n_err++; $display("[TB] FAIL enc_op%0d: got v=%b %h@%h want v=1 %h@%h", tm[k], out_valid, out_wdata, out_addr, te[k], exp_addr); end
      tick();
      exp_addr = exp_addr + 8'd1;
    end
  endtask

  task automatic test_illegal();
    send(4'd12, 3'd1, 3'd1, 3'd1, 2'd1, 16'd1);
    n_cmp++; if (out_valid !== 1'b0 || err_illegal !== 1'b1) begin n_err++; $display("[TB] FAIL illegal_flag: got v=%b err=%b want v=0 err=1", out_valid, err_illegal); end
    n_cmp++; if (out_addr !== exp_addr || in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL illegal_addr: got %h rdy=%b want %h rdy=1", out_addr, in_ready, exp_addr); end
  endtask

  task automatic test_halt();
    send(4'd8, 3'd3, 3'd3, 3'd3, 2'd3, 16'hFFFF);
    n_cmp++; if (out_wdata !== 16'hE000 || out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL halt_word: got v=%b %h want v=1 E000", out_valid, out_wdata); end
    tick();
    tick();
    n_cmp++; if (done !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL halt_done: got d=%b rdy=%b v=%b want d=1 rdy=0 v=0", done, in_ready, out_valid); end
    do_restart();
    n_cmp++; if (out_addr !== 8'h00 || done !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL halt_restart: got a=%h d=%b rdy=%b want a=00 d=0 rdy=1", out_addr, done, in_ready); end
    n_cmp++; if (count !== 9'd0 || err_illegal !== 1'b0) begin n_err++; $display("[TB] FAIL restart_clear: got cnt=%0d err=%b want cnt=0 err=0", count, err_illegal); end
  endtask

  task automatic test_restart_priority();
    out_ready = 1'b0;
    send(4'd0, 3'd2, 3'd0, 3'd0, 2'd0, 16'd3);
    out_ready = 1'b1;
    do_restart();
    n_cmp++; if (count !== 9'd0 || out_valid !== 1'b0 || out_addr !== 8'h00) begin n_err++; $display("[TB] FAIL restart_prio: got cnt=%0d v=%b a=%h want cnt=0 v=0 a=00", count, out_valid, out_addr); end
  endtask

  task automatic test_imm();
    out_ready = 1'b1;
    send(4'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'd200);
`ifdef IENC_IMM_CHECK_EN
    n_cmp++; if (out_valid !== 1'b0 || err_imm !== 1'b1) begin n_err++; $display("[TB] FAIL imm_reject: got v=%b err=%b want v=0 err=1", out_valid, err_imm); end
`else
    n_cmp++; if (out_valid !== 1'b1 || out_wdata !== 16'hD0C8 || err_imm !== 1'b0) begin n_err++; $display("[TB] FAIL imm_trunc: got v=%b %h err=%b want v=1 D0C8 err=0", out_valid, out_wdata, err_imm); end
    tick();
`endif
    do_restart();
  endtask

  task automatic test_full();
    out_ready = 1'b1;
    for (int k = 0; k < 255; k++) begin
      send(4'd0, 3'(k % 8), 3'd0, 3'd0, 2'd0, 16'(k));
      tick();
    end
    n_cmp++; if (out_addr !== 8'hFF || full !== 1'b0 || done !== 1'b0 || count !== 9'd255) begin n_err++; $display("[TB] FAIL full_pre: got a=%h f=%b d=%b cnt=%0d want a=FF f=0 d=0 cnt=255", out_addr, full, done, count); end
    send(4'd0, 3'd7, 3'd0, 3'd0, 2'd0, 16'd255);
    n_cmp++; if (out_wdata !== 16'hD7FF) begin n_err++; $display("[TB] FAIL full_word: got %h want D7FF", out_wdata); end
    tick();
    n_cmp++; if (full !== 1'b1 || done !== 1'b1 || count !== 9'd256 || in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL full_post: got f=%b d=%b cnt=%0d rdy=%b want f=1 d=1 cnt=256 rdy=0", full, done, count, in_ready); end
    do_restart();
  endtask

  task automatic test_reset_mid_write();
    out_ready = 1'b0;
    send(4'd0, 3'd4, 3'd0, 3'd0, 2'd0, 16'd9);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL rstmid_pre: got v=%b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_wdata !== 16'h0000 || count !== 9'd0) begin n_err++; $display("[TB] FAIL rstmid_drop: got v=%b %h cnt=%0d want v=0 0000 cnt=0", out_valid, out_wdata, count); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1 || out_addr !== 8'h00 || out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_after: got rdy=%b a=%h v=%b want rdy=1 a=00 v=0", in_ready, out_addr, out_valid); end
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_back_to_back();
    test_stall();
    test_encodings();
    test_illegal();
    test_halt();
    test_restart_priority();
    test_imm();
    test_full();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
